// File: rtl/bcd_sched_pkg.sv
// rtl/bcd_sched_pkg.sv - shared types, digit geometry and the double-dabble correction step
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIG_W = 4;
  localparam int NDIG  = 3;

  function automatic logic [DIG_W-1:0] add3_if_ge5(input logic [DIG_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// rtl/bcd_conv_sched_if.sv - request/result bundle between requesters and the BCD scheduler
interface bcd_conv_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]    req;
  logic [NCH*W-1:0]  bin_flat;
  logic [NCH-1:0]    ack;
  logic [NCH*12-1:0] bcd_flat;
  logic              valid;
  logic [CW-1:0]     ch_id;
  logic              busy;

  modport master (output req, bin_flat, input ack, bcd_flat, valid, ch_id, busy);
  modport slave  (input req, bin_flat, output ack, bcd_flat, valid, ch_id, busy);
endinterface

// File: rtl/bcd_shift_core.sv
// rtl/bcd_shift_core.sv - serial double-dabble datapath: binary shift register plus three BCD digits
module bcd_shift_core
  import bcd_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     load_val,
  output logic [DIG_W-1:0] hundreds,
  output logic [DIG_W-1:0] tens,
  output logic [DIG_W-1:0] ones
);
  logic [W-1:0]     bin_q, bin_d;
  logic [DIG_W-1:0] hun_q, hun_d, ten_q, ten_d, one_q, one_d;
  logic [DIG_W-1:0] hun_a, ten_a, one_a;

  always_comb begin
    hun_a = add3_if_ge5(hun_q);
    ten_a = add3_if_ge5(ten_q);
    one_a = add3_if_ge5(one_q);
    bin_d = bin_q;
    hun_d = hun_q;
    ten_d = ten_q;
    one_d = one_q;
    if (load) begin
      bin_d = load_val;
      hun_d = '0;
      ten_d = '0;
      one_d = '0;
    end else if (step) begin
      // hundreds MSB is dropped: W<=8 never reaches it
      {hun_d, ten_d, one_d, bin_d} = {hun_a[DIG_W-2:0], ten_a, one_a, bin_q, 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      hun_q <= '0;
      ten_q <= '0;
      one_q <= '0;
    end else begin
      bin_q <= bin_d;
      hun_q <= hun_d;
      ten_q <= ten_d;
      one_q <= one_d;
    end
  end

  assign hundreds = hun_q;
  assign tens     = ten_q;
  assign ones     = one_q;
endmodule

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin scheduler sharing one serial binary-to-BCD engine among NCH channels
// Optional BCD_SKIP_SAME_EN: re-grants of an unchanged value skip the shift phase.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  bcd_conv_sched_if.slave bus
);
  localparam int CW    = $clog2(NCH);
  localparam int CNT_W = $clog2(W);
  localparam int RW    = NDIG * DIG_W;

  state_t           state_q, state_d;
  logic [CW-1:0]    ptr_q, ptr_d, ch_q, ch_d, gnt_idx, cand;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH*RW-1:0] bcd_q, bcd_d;
  logic             gnt_found, load, step;
  logic [W-1:0]     gnt_bin;
  logic [DIG_W-1:0] hundreds, tens, ones;
`ifdef BCD_SKIP_SAME_EN
  logic [NCH*W-1:0] last_q, last_d;
  logic [NCH-1:0]   seen_q, seen_d;
  logic [W-1:0]     cur_q, cur_d;
  logic             skip_q, skip_d;
`endif

  // first requester at or above the pointer, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = CW'((int'(ptr_q) + i) % NCH);
      if (!gnt_found && bus.req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_bin = bus.bin_flat[int'(gnt_idx)*W +: W];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    load    = 1'b0;
    step    = 1'b0;
`ifdef BCD_SKIP_SAME_EN
    last_d  = last_q;
    seen_d  = seen_q;
    cur_d   = cur_q;
    skip_d  = skip_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ch_d    = gnt_idx;
          cnt_d   = CNT_W'(W - 1);
          load    = 1'b1;
          state_d = SHIFT;
`ifdef BCD_SKIP_SAME_EN
          cur_d  = gnt_bin;
          skip_d = 1'b0;
          if (seen_q[gnt_idx] && gnt_bin == last_q[int'(gnt_idx)*W +: W]) begin
            load    = 1'b0;
            skip_d  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
`ifdef BCD_SKIP_SAME_EN
        // a skipped grant leaves the slot as it already is
        if (!skip_q) begin
          bcd_d[int'(ch_q)*RW +: RW] = {hundreds, tens, ones};
          last_d[int'(ch_q)*W +: W]  = cur_q;
          seen_d[ch_q]               = 1'b1;
        end
`else
        bcd_d[int'(ch_q)*RW +: RW] = {hundreds, tens, ones};
`endif
        ptr_d   = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
`ifdef BCD_SKIP_SAME_EN
      last_q  <= '0;
      seen_q  <= '0;
      cur_q   <= '0;
      skip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
`ifdef BCD_SKIP_SAME_EN
      last_q  <= last_d;
      seen_q  <= seen_d;
      cur_q   <= cur_d;
      skip_q  <= skip_d;
`endif
    end
  end

  bcd_shift_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .load_val (gnt_bin),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  assign bus.ack      = (state_q == DONE) ? (NCH'(1) << ch_q) : '0;
  assign bus.valid    = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.ch_id    = ch_q;
  assign bus.bcd_flat = bcd_q;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - directed and randomized checks of bcd_conv_sched against a decimal reference
module tb_bcd_conv_sched;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_conv_sched_if #(.NCH(NCH), .W(W)) bus ();
  bcd_conv_sched #(.NCH(NCH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [11:0] model_bcd [NCH];
  int          tb_bin [NCH];
  int          model_ptr;
  int          n, exp_ch, rounds_left;
  logic        busy_all, ack_seen;
  logic [NCH-1:0] mask;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [NCH*12-1:0] model_flat();
    logic [NCH*12-1:0] f;
    for (int k = 0; k < NCH; k++) f[k*12 +: 12] = model_bcd[k];
    return f;
  endfunction

  function automatic int model_grant(input logic [NCH-1:0] r);
    for (int i = 0; i < NCH; i++)
      if (r[(model_ptr + i) % NCH]) return (model_ptr + i) % NCH;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) model_bcd[k] = '0;
    model_ptr = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bin(input int ch, input int v);
    tb_bin[ch] = v;
    bus.bin_flat[ch*W +: W] = W'(v);
  endtask

  task automatic wait_ack(output int cnt, output logic ball);
    cnt  = 0;
    ball = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
      ball &= bus.busy;
    end while (bus.ack == '0 && cnt < 40);
  endtask

  task automatic convert_one(input int ch, input int v);
    int c;
    logic b;
    @(negedge clk);
    set_bin(ch, v);
    bus.req = NCH'(1 << ch);
    wait_ack(c, b);
    check("latency", c, W + 1);
    check("busy_during", b, 1);
    check("ack", bus.ack, 1 << ch);
    check("valid", bus.valid, 1);
    check("ch_id", bus.ch_id, ch);
    bus.req = '0;
    model_bcd[ch] = ref_bcd(v);
    model_ptr = (ch + 1) % NCH;
    @(negedge clk);
    check("slots", bus.bcd_flat, model_flat());
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int bvals[6];
    logic [11:0] bexp[6];
    int rrv[4];
    bvals = '{0, 9, 10, 99, 100, 128};
    bexp  = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
    rrv   = '{59, 23, 7, 31};

    rst = 1'b1;
    bus.req = '0;
    bus.bin_flat = '0;
    for (int k = 0; k < NCH; k++) tb_bin[k] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ack", bus.ack, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ch_id", bus.ch_id, 0);
    check("rst_bcd", bus.bcd_flat, 0);
    rst = 1'b0;

    convert_one(0, 255);
    check("single_255", bus.bcd_flat[11:0], 12'h255);

    for (int i = 0; i < 6; i++) begin
      convert_one(1, bvals[i]);
      check("boundary", bus.bcd_flat[23:12], bexp[i]);
    end

    for (int v = 0; v < 256; v++) convert_one(int'($urandom_range(0, NCH - 1)), v);

    // fairness with all four requests held throughout
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < NCH; k++) set_bin(k, rrv[k]);
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n, busy_all);
      exp_ch = model_grant(bus.req);
      check("rr_spacing", n, (k == 0) ? W + 1 : W + 2);
      check("rr_ack", bus.ack, 1 << exp_ch);
      check("rr_ch_id", bus.ch_id, exp_ch);
      model_bcd[exp_ch] = ref_bcd(tb_bin[exp_ch]);
      model_ptr = (exp_ch + 1) % NCH;
    end
    bus.req = '0;
    @(negedge clk);
    check("rr_slots", bus.bcd_flat, model_flat());
    check("rr_slot0", bus.bcd_flat[11:0], 12'h059);
    check("rr_slot3", bus.bcd_flat[47:36], 12'h031);

    // random request masks, each requester dropping on its own ack
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      mask = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int k = 0; k < NCH; k++) set_bin(k, int'($urandom_range(0, 255)));
      bus.req = mask;
      rounds_left = $countones(mask);
      for (int k = 0; k < rounds_left; k++) begin
        wait_ack(n, busy_all);
        exp_ch = model_grant(bus.req);
        check("rand_spacing", n, (k == 0) ? W + 1 : W + 2);
        check("rand_ack", bus.ack, 1 << exp_ch);
        model_bcd[exp_ch] = ref_bcd(tb_bin[exp_ch]);
        model_ptr = (exp_ch + 1) % NCH;
        if (exp_ch >= 0) bus.req[exp_ch] = 1'b0;
      end
      bus.req = '0;
      @(negedge clk);
      check("rand_slots", bus.bcd_flat, model_flat());
    end

    // ch2 withdraws mid-conversion, then the pointer must sit on ch3
    @(negedge clk);
    set_bin(2, int'($urandom_range(0, 255)));
    bus.req = NCH'(4'b0100);
    repeat (3) @(negedge clk);
    bus.req = '0;
    wait_ack(n, busy_all);
    check("wd_latency", n + 3, W + 1);
    check("wd_ack", bus.ack, 4'b0100);
    model_bcd[2] = ref_bcd(tb_bin[2]);
    model_ptr = 3;
    bus.req = NCH'(4'b1011);
    wait_ack(n, busy_all);
    check("wd_next_spacing", n, W + 2);
    check("wd_next_ack", bus.ack, 1 << model_grant(4'b1011));
    model_bcd[3] = ref_bcd(tb_bin[3]);
    model_ptr = 0;
    bus.req = '0;
    @(negedge clk);
    check("wd_slots", bus.bcd_flat, model_flat());

    // asynchronous reset in the middle of a conversion
    set_bin(0, 200);
    bus.req = NCH'(1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_valid", bus.valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_bcd", bus.bcd_flat, 0);
    check("mid_rst_ch_id", bus.ch_id, 0);
    bus.req = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ack_seen |= (bus.ack != '0);
    end
    check("post_rst_no_ack", ack_seen, 0);
    convert_one(0, 200);
    check("post_rst_200", bus.bcd_flat[11:0], 12'h200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
